mem_stage: RTL

- MEM pipeline stage between EX and WB; the transmitter end of the MEM->WB valid/allowin handshake.
- Latches the EX->MEM bus and, for loads/stores, waits for the data SRAM response (data_ok/rdata).
- Aligns and extends load data, then presents the MEM->WB bus.
- Also drives a forwarding bus for ID-stage bypass/stall.

---
 rtl/mem_stage_pkg.sv | 49 ++++
 rtl/mem_load_align.sv | 38 +++
 rtl/mem_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts, FSM states and load_op bit positions for the MEM stage.
// Pure declarations; no logic.
package mem_stage_pkg;

  localparam int EX_to_MEM_LEN = 77;
  localparam int MEM_to_WB_LEN = 103;
  localparam int MEM_RF_LEN    = 38;
  localparam int DEST_LEN      = 5;

  // load_op is one-hot {lb, lbu, lh, lhu, lw}
  localparam int LD_LW  = 0;
  localparam int LD_LHU = 1;
  localparam int LD_LH  = 2;
  localparam int LD_LBU = 3;
  localparam int LD_LB  = 4;

  typedef enum logic [1:0] {
    MEM_S_EMPTY = 2'd0,
    MEM_S_WAIT  = 2'd1,
    MEM_S_HOLD  = 2'd2,
    MEM_S_PASS  = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [31:0]         pc;
    logic                gr_we;
    logic [DEST_LEN-1:0] dest;
    logic [31:0]         alu_result;
    logic [4:0]          load_op;
    logic                rfrom_mem;
    logic                mem_wait;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0]         pc;
    logic                gr_we;
    logic [DEST_LEN-1:0] dest;
    logic [31:0]         mem_result;
    logic [31:0]         alu_result;
    logic                rfrom_mem;
  } mem_wb_t;

  typedef struct packed {
    logic [DEST_LEN-1:0] dest;
    logic                data_pending;
    logic [31:0]         final_result;
  } mem_rf_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects byte/halfword by address offset and sign/zero-extends.
// Purely combinational; no state, no backpressure.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [4:0]  load_op,
  output logic [31:0] mem_result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw[7:0];
    case (off)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = off[1] ? raw[31:16] : raw[15:0];

    // Non-one-hot encodings fall through to the raw word
    mem_result = raw;
    case (load_op)
      5'(1 << LD_LB):  mem_result = {{24{byte_sel[7]}}, byte_sel};
      5'(1 << LD_LBU): mem_result = {24'd0, byte_sel};
      5'(1 << LD_LH):  mem_result = {{16{half_sel[15]}}, half_sel};
      5'(1 << LD_LHU): mem_result = {16'd0, half_sel};
      5'(1 << LD_LW):  mem_result = raw;
      default:         mem_result = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EX payload, waits for data SRAM response, aligns loads, hands to WB.
// Latency: 1 cycle for non-memory ops; memory ops pass through in the data_ok cycle when WB allows.
// Backpressure: valid/allowin to WB; response buffered in HOLD if WB stalls. MEM_STALL_CNT_EN adds a stall counter.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [EX_to_MEM_LEN-1:0] EX_to_MEM_BUS,
  input  logic                     EX_to_MEM_valid,
  output logic                     MEM_allowin,
  output logic [MEM_to_WB_LEN-1:0] MEM_to_WB_BUS,
  output logic                     MEM_to_WB_valid,
  input  logic                     WB_allowin,
  input  logic                     data_sram_data_ok,
  input  logic [31:0]              data_sram_rdata,
  output logic [MEM_RF_LEN-1:0]    MEM_RF_BUS
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0]              mem_stall_cnt
`endif
);

  mem_state_e  state, state_nxt;
  ex_mem_t     ex_in, pl;
  mem_wb_t     wb;
  mem_rf_t     rf;
  logic [31:0] rdata_buf;
  logic [31:0] raw;
  logic [31:0] mem_result;
  logic [31:0] final_result;
  logic        mem_valid;
  logic        ready_go;
  logic        accept;

  assign ex_in     = ex_mem_t'(EX_to_MEM_BUS);
  assign mem_valid = (state != MEM_S_EMPTY);
  assign ready_go  = (state == MEM_S_PASS) || (state == MEM_S_HOLD) ||
                     ((state == MEM_S_WAIT) && data_sram_data_ok);

  assign MEM_allowin     = !mem_valid || (ready_go && WB_allowin);
  assign MEM_to_WB_valid = mem_valid && ready_go;
  assign accept          = EX_to_MEM_valid && MEM_allowin;

  always_comb begin
    state_nxt = state;
    if (MEM_allowin) begin
      if (EX_to_MEM_valid) state_nxt = ex_in.mem_wait ? MEM_S_WAIT : MEM_S_PASS;
      else                 state_nxt = MEM_S_EMPTY;
    end else if ((state == MEM_S_WAIT) && data_sram_data_ok) begin
      state_nxt = MEM_S_HOLD;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= MEM_S_EMPTY;
      pl        <= '0;
      rdata_buf <= '0;
    end else begin
      state <= state_nxt;
      if (accept) pl <= ex_in;
      if ((state == MEM_S_WAIT) && data_sram_data_ok && !WB_allowin)
        rdata_buf <= data_sram_rdata;
    end
  end

  // Empty stage presents zero data so idle outputs do not follow the SRAM bus
  assign raw = (state == MEM_S_HOLD) ? rdata_buf :
               (mem_valid ? data_sram_rdata : 32'd0);

  mem_load_align u_align (
    .raw        (raw),
    .off        (pl.alu_result[1:0]),
    .load_op    (pl.load_op),
    .mem_result (mem_result)
  );

  assign final_result = pl.rfrom_mem ? mem_result : pl.alu_result;

  always_comb begin
    wb.pc         = pl.pc;
    wb.gr_we      = pl.gr_we;
    wb.dest       = pl.dest;
    wb.mem_result = mem_result;
    wb.alu_result = pl.alu_result;
    wb.rfrom_mem  = pl.rfrom_mem;
  end
  assign MEM_to_WB_BUS = wb;

  always_comb begin
    rf.dest         = pl.dest & {DEST_LEN{mem_valid & pl.gr_we}};
    rf.data_pending = mem_valid & pl.rfrom_mem & !ready_go;
    rf.final_result = final_result;
  end
  assign MEM_RF_BUS = rf;

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_stall_cnt <= '0;
    end else if ((mem_valid && !MEM_to_WB_valid) || (MEM_to_WB_valid && !WB_allowin)) begin
      mem_stall_cnt <= mem_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
